// File: rtl/filter_mac_scheduler_if.sv
// Control bundle between the filter MAC scheduler and the UART/datapath side.
// Ticks and strobes are single-cycle pulses sampled on the rising clock edge; no back-pressure exists.
interface filter_mac_scheduler_if #(
    parameter int SEL_W = 3
);
    logic             rx_done_tick;
    logic             tx_done_tick;
    logic             clr_ovr;
    logic             en_shift;
    logic             clr_acc;
    logic             en_acc;
    logic [SEL_W-1:0] sel_tap;
    logic             en_out;
    logic             tx_start;
    logic             busy;
    logic             listo;
    logic             overrun;
    logic [2:0]       state;

    modport master (
        input  rx_done_tick, tx_done_tick, clr_ovr,
        output en_shift, clr_acc, en_acc, sel_tap, en_out, tx_start,
               busy, listo, overrun, state
    );

    modport slave (
        output rx_done_tick, tx_done_tick, clr_ovr,
        input  en_shift, clr_acc, en_acc, sel_tap, en_out, tx_start,
               busy, listo, overrun, state
    );
endinterface

// File: rtl/filter_mac_scheduler.sv
// Sequences the shared multiply-accumulate datapath once per received sample:
// shift, clear, TAPS accumulate cycles, load output, transmit and wait for tx completion.
module filter_mac_scheduler #(
    parameter int TAPS  = 4,
    parameter int SEL_W = 3
) (
    input logic                    clk,
    input logic                    reset,
    filter_mac_scheduler_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, SHIFT, CLEAR, MAC, LOAD, SEND, WAIT_TX, DONE
    } state_t;

    localparam logic [SEL_W-1:0] LAST_TAP = SEL_W'(TAPS - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] counter_q, counter_d;
    logic             overrun_q;
    logic             busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            // A new sample during a computation outranks a simultaneous clear.
            if (bus.rx_done_tick && busy)
                overrun_q <= 1'b1;
            else if (bus.clr_ovr)
                overrun_q <= 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        busy         = 1'b1;
        bus.en_shift = 1'b0;
        bus.clr_acc  = 1'b0;
        bus.en_acc   = 1'b0;
        bus.en_out   = 1'b0;
        bus.tx_start = 1'b0;
        bus.listo    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (bus.rx_done_tick) state_d = SHIFT;
            end
            SHIFT: begin
                bus.en_shift = 1'b1;
                state_d      = CLEAR;
            end
            CLEAR: begin
                bus.clr_acc = 1'b1;
                counter_d   = '0;
                state_d     = MAC;
            end
            MAC: begin
                bus.en_acc = 1'b1;
                // Counter returns to zero on exit so sel_tap idles at 0.
                if (counter_q == LAST_TAP) begin
                    counter_d = '0;
                    state_d   = LOAD;
                end else begin
                    counter_d = counter_q + SEL_W'(1);
                end
            end
            LOAD: begin
                bus.en_out = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                bus.tx_start = 1'b1;
                state_d      = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.tx_done_tick) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b0;
                bus.listo = 1'b1;
                state_d   = bus.rx_done_tick ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy    = busy;
    assign bus.sel_tap = counter_q;
    assign bus.overrun = overrun_q;
    assign bus.state   = state_q;
endmodule

// File: doc/filter_mac_scheduler.md
Name: filter_mac_scheduler

Overview:
Control FSM that sequences the shared multiply-accumulate datapath of the filter once per received sample. A new sample is signalled by the UART rx_done_tick. The block shifts the sample delay line, clears the accumulator, steps the tap/coefficient mux through TAPS products, loads the output register and hands the result to the UART transmitter. It flags samples that arrive while a computation is in progress.

Parameters:
TAPS, 4, number of tap products per sample; legal range 1..2^SEL_W
SEL_W, 3, width of the tap/coefficient mux select

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
rx_done_tick  in  1  one-cycle pulse: new sample byte available from UART rx
tx_done_tick  in  1  one-cycle pulse: UART tx finished sending
clr_ovr  in  1  clears the sticky overrun flag
en_shift  out  1  shift the sample delay line (one cycle)
clr_acc  out  1  synchronous clear of the accumulator (one cycle)
en_acc  out  1  accumulate the product selected by sel_tap
sel_tap  out  SEL_W  tap/coefficient mux select
en_out  out  1  load the output register from the accumulator (one cycle)
tx_start  out  1  one-cycle start pulse to UART tx
busy  out  1  high in every state except IDLE and DONE
listo  out  1  one-cycle pulse: result sent
overrun  out  1  sticky: a sample arrived while busy

Behaviour:
- States: IDLE, SHIFT, CLEAR, MAC, LOAD, SEND, WAIT_TX, DONE. Moore outputs are decoded from the state register. sel_tap is the tap counter register.
- Reset (reset=0): applied asynchronously. State=IDLE, tap counter=0, overrun=0. All outputs are 0 while reset is low and immediately after release. Reset mid-operation abandons the computation with no listo or tx_start.
- IDLE: rx_done_tick=1 -> SHIFT; otherwise stay.
- SHIFT: en_shift=1 -> CLEAR.
- CLEAR: clr_acc=1, counter<=0 -> MAC.
- MAC: en_acc=1, sel_tap=counter.
  - If counter==TAPS-1 -> LOAD, counter<=0.
  - Otherwise counter<=counter+1.
  - MAC lasts exactly TAPS cycles, with sel_tap going 0..TAPS-1. TAPS=1 gives a single MAC cycle.
- LOAD: en_out=1 -> SEND.
- SEND: tx_start=1 -> WAIT_TX.
- WAIT_TX: stay until tx_done_tick=1, then -> DONE. There is no timeout.
- DONE: listo=1 for one cycle.
  - rx_done_tick=1 -> SHIFT (back-to-back sample accepted, no overrun).
  - Otherwise -> IDLE.
- Latency: rx_done_tick sampled at edge 0 gives en_shift in cycle 1, clr_acc in 2, en_acc in 3..TAPS+2, en_out in TAPS+3, tx_start in TAPS+4. listo follows one cycle after tx_done_tick is sampled in WAIT_TX.
- rx_done_tick while busy=1 sets overrun on the next edge. The sample is dropped and the sequence is unaffected.
- clr_ovr=1 clears overrun on the next edge. If set and clear happen in the same cycle, set wins.
- tx_done_tick in any state other than WAIT_TX is ignored.
- At most one of en_shift, clr_acc, en_acc, en_out, tx_start is high in any cycle.
- sel_tap is 0 outside MAC.

Test Plan:
1. Hold reset=0 for 3 cycles, then release with no stimulus -> all outputs 0, state IDLE, busy=0 indefinitely.
2. TAPS=4, rx pulse at edge 0, tx_done_tick pulse at edge 12 -> en_shift@1, clr_acc@2, en_acc@3..6 with sel_tap 0,1,2,3, en_out@7, tx_start@8, busy@1..12, listo@13, IDLE@14.
3. As in 2, plus an rx pulse at cycle 4 -> overrun=1 from cycle 5 with the sequence timing unchanged. clr_ovr pulse -> overrun=0 next cycle. rx while busy together with clr_ovr in the same cycle -> overrun stays 1.
4. rx_done_tick held at 1 continuously -> DONE goes straight to SHIFT, and sequences repeat every TAPS+6 cycles plus the tx wait. overrun=1 after the first busy cycle.
5. reset driven low during MAC at sel_tap=2 -> outputs 0 immediately, overrun 0. After release, a new rx pulse runs the full sequence from sel_tap=0.
6. tx_done_tick pulses in IDLE, MAC and SEND -> ignored. The FSM remains in WAIT_TX until a tick arrives there, and listo fires only once.
